// File: rtl/lattice_mem_pkg.sv
// Shared constants and types for the D2Q9 distribution RAM bank set and its
// port arbiter.
package lattice_mem_pkg;

  localparam int NUM_DIR       = 9;
  localparam int DATA_WIDTH    = 16;
  localparam int DEPTH         = 2500;
  localparam int ADDRESS_WIDTH = 12;
  localparam int MAX_BURST     = 16;
  localparam int W             = DATA_WIDTH * NUM_DIR;
  localparam int CNT_WIDTH     = $clog2(MAX_BURST + 1);

  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_ADDR = ADDRESS_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX    = CNT_WIDTH'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SOL  = 2'd1,
    OWN_RD   = 2'd2
  } owner_t;

  // Lane order inside the W-bit bus: lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
  localparam int DIR_C0 = 0;
  localparam int DIR_N  = 1;
  localparam int DIR_NE = 2;
  localparam int DIR_E  = 3;
  localparam int DIR_SE = 4;
  localparam int DIR_S  = 5;
  localparam int DIR_SW = 6;
  localparam int DIR_W  = 7;
  localparam int DIR_NW = 8;

  function automatic int lane_lsb(input int dir);
    return dir * DATA_WIDTH;
  endfunction

endpackage

// File: rtl/lattice_bank_arbiter_if.sv
// Requester and RAM-side signal bundle of the bank arbiter. The slave view is
// the arbiter; the master view is the surrounding requesters plus the RAMs.
interface lattice_bank_arbiter_if;
  import lattice_mem_pkg::*;

  logic                     sol_req;
  logic                     sol_we;
  logic                     sol_last;
  logic [ADDRESS_WIDTH-1:0] sol_addr;
  logic [W-1:0]             sol_wdata;
  logic                     sol_gnt;
  logic                     sol_rvalid;

  logic                     rd_req;
  logic                     rd_last;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic                     rd_gnt;
  logic                     rd_rvalid;

  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_we;
  logic [W-1:0]             mem_wdata;
  logic [W-1:0]             mem_rdata;
  logic                     oob_err;

  // mem_rdata is consumed directly by the requesters, qualified by their rvalid.
  modport slave (
    input  sol_req, sol_we, sol_last, sol_addr, sol_wdata,
    input  rd_req, rd_last, rd_addr,
    output sol_gnt, sol_rvalid, rd_gnt, rd_rvalid,
    output mem_addr, mem_we, mem_wdata, oob_err
  );

  modport master (
    output sol_req, sol_we, sol_last, sol_addr, sol_wdata,
    output rd_req, rd_last, rd_addr,
    input  sol_gnt, sol_rvalid, rd_gnt, rd_rvalid,
    input  mem_addr, mem_we, mem_wdata, oob_err,
    output mem_rdata
  );

endinterface

// File: rtl/lattice_bank_arbiter_arb_rr2.sv
// Two-way round-robin pick used when the port is idle; on a tie the requester
// that did not own the previous burst wins.
module arb_rr2
  import lattice_mem_pkg::*;
(
  input  logic   sol_req,
  input  logic   rd_req,
  input  owner_t last_owner,
  output owner_t pick
);

  always_comb begin
    pick = OWN_NONE;
    if (sol_req && rd_req) begin
      pick = (last_owner == OWN_SOL) ? OWN_RD : OWN_SOL;
    end else if (sol_req) begin
      pick = OWN_SOL;
    end else if (rd_req) begin
      pick = OWN_RD;
    end
  end

endmodule

// File: rtl/lattice_bank_arbiter.sv
// Burst-granular round-robin owner of the shared D2Q9 RAM address/write port,
// with tagged read-valid strobes matching the RAMs' one-cycle read latency.
module lattice_bank_arbiter
  import lattice_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  lattice_bank_arbiter_if.slave  bus
);

  owner_t                 state_reg, state_next;
  owner_t                 last_owner_reg, last_owner_next;
  owner_t                 idle_pick, other_owner;
  logic [CNT_WIDTH-1:0]   beat_cnt_reg, beat_cnt_next, beat_cnt_inc;
  logic                   sol_rvalid_reg, rd_rvalid_reg, oob_err_reg;
  logic                   owner_req, owner_last, other_req;
  logic                   beat, burst_end, beat_oob;
  logic [ADDRESS_WIDTH-1:0] owner_addr;

  arb_rr2 u_arb_rr2 (
    .sol_req    (bus.sol_req),
    .rd_req     (bus.rd_req),
    .last_owner (last_owner_reg),
    .pick       (idle_pick)
  );

  always_comb begin
    owner_req   = 1'b0;
    owner_last  = 1'b0;
    owner_addr  = '0;
    other_req   = 1'b0;
    other_owner = OWN_NONE;
    case (state_reg)
      OWN_SOL: begin
        owner_req   = bus.sol_req;
        owner_last  = bus.sol_last;
        owner_addr  = bus.sol_addr;
        other_req   = bus.rd_req;
        other_owner = OWN_RD;
      end
      OWN_RD: begin
        owner_req   = bus.rd_req;
        owner_last  = bus.rd_last;
        owner_addr  = bus.rd_addr;
        other_req   = bus.sol_req;
        other_owner = OWN_SOL;
      end
      default: ;
    endcase
  end

  // owner_req is forced low in IDLE, so it alone qualifies a beat.
  assign beat         = owner_req;
  assign beat_cnt_inc = beat_cnt_reg + CNT_WIDTH'(1);
  assign burst_end    = (state_reg != OWN_NONE) &&
                        (!owner_req || owner_last || (beat_cnt_inc == CNT_MAX));
  assign beat_oob     = beat && (owner_addr >= DEPTH_ADDR);

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    if (state_reg == OWN_NONE) begin
      state_next    = idle_pick;
      beat_cnt_next = '0;
    end else if (burst_end) begin
      last_owner_next = state_reg;
      beat_cnt_next   = '0;
      if (other_req) begin
        state_next = other_owner;
      end else if (owner_req) begin
        state_next = state_reg;
      end else begin
        state_next = OWN_NONE;
      end
    end else begin
      beat_cnt_next = beat_cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= OWN_NONE;
      last_owner_reg <= OWN_RD;
      beat_cnt_reg   <= '0;
      sol_rvalid_reg <= 1'b0;
      rd_rvalid_reg  <= 1'b0;
      oob_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      sol_rvalid_reg <= beat && (state_reg == OWN_SOL) && !bus.sol_we;
      rd_rvalid_reg  <= beat && (state_reg == OWN_RD);
      if (beat_oob) begin
        oob_err_reg <= 1'b1;
      end
    end
  end

  assign bus.sol_gnt    = (state_reg == OWN_SOL);
  assign bus.rd_gnt     = (state_reg == OWN_RD);
  assign bus.sol_rvalid = sol_rvalid_reg;
  assign bus.rd_rvalid  = rd_rvalid_reg;
  assign bus.oob_err    = oob_err_reg;
  assign bus.mem_addr   = owner_addr;
  assign bus.mem_we     = bus.sol_gnt && bus.sol_req && bus.sol_we &&
                          (bus.sol_addr < DEPTH_ADDR);

  // Only the solver writes; the lane bus reads as zero otherwise.
  generate
    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lane
      assign bus.mem_wdata[lane_lsb(gi) +: DATA_WIDTH] =
        (state_reg == OWN_SOL) ? bus.sol_wdata[lane_lsb(gi) +: DATA_WIDTH]
                               : {DATA_WIDTH{1'b0}};
    end
  endgenerate

endmodule

// File: doc/lattice_bank_arbiter.md
# lattice_bank_arbiter

Arbitrates the shared address/write port of the nine D2Q9 distribution RAMs (one 16-bit bank per direction, common address) between two requesters: the solver update engine (read/write) and the AXI-Stream readout controller (read-only). Grants are burst-granular and round-robin, with zero-bubble handover. The block sits between both requesters and the RAM bank set, and returns tagged read-valid strobes aligned to the RAMs' 1-cycle read latency.

## Interface
- DATA_WIDTH, 16, bits per direction lane
- NUM_DIR, 9, directions/banks; lane bus width W = DATA_WIDTH*NUM_DIR (144)
- DEPTH, 2500, cells per bank (50x50 lattice)
- ADDRESS_WIDTH, 12, cell address width
- MAX_BURST, 16, maximum beats per grant
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- sol_req / sol_we / sol_last  in  1 each  solver beat request, write enable, last beat of burst
- sol_addr  in  ADDRESS_WIDTH  solver cell address
- sol_wdata  in  W  solver write lanes
- sol_gnt  out  1  solver owns port
- sol_rvalid  out  1  mem_rdata is valid for the solver
- rd_req / rd_last  in  1 each  readout beat request, last beat
- rd_addr  in  ADDRESS_WIDTH  readout cell address
- rd_gnt  out  1  readout owns port
- rd_rvalid  out  1  mem_rdata is valid for readout
- mem_addr  out  ADDRESS_WIDTH  common bank address
- mem_we  out  1  common bank write enable
- mem_wdata  out  W  bank write lanes
- mem_rdata  in  W  bank read lanes (registered inside the RAMs)
- oob_err  out  1  sticky out-of-range flag

## Operation
- States: IDLE, OWN_SOL, OWN_RD. sol_gnt = (state==OWN_SOL); rd_gnt = (state==OWN_RD). Both are registered.
- A beat is issued in a cycle where the owner's req and gnt are both high.
- mem_addr and mem_wdata are muxed combinationally from the owner; in IDLE they hold 0.
- mem_we = sol_gnt & sol_req & sol_we & (sol_addr < DEPTH).
- rd_we does not exist; readout beats are always reads.
- Round-robin pointer `last_owner` updates at every burst end. It resets to RD, so the solver wins the first tie.
- Burst ends on any of:
  - a beat with last=1;
  - the MAX_BURST-th beat (beat counter hits MAX_BURST);
  - owner req low while granted (no beat that cycle).
- At burst end, next state:
  - the other requester if its req is high;
  - else the same requester if its req is high (new burst, counter cleared);
  - else IDLE.
- From IDLE: one req high → grant it; both high → grant the one that is not `last_owner`.
- Read beats (readout beat, or solver beat with sol_we=0) set the matching rvalid one cycle later for exactly one cycle. mem_rdata passes through unregistered.
- Address ≥ DEPTH:
  - the beat is still consumed and counted;
  - write is suppressed;
  - rvalid is still returned (data undefined);
  - oob_err sets and stays high until rst.
- Requesters may change addr/we/wdata every cycle; the block holds no request state.

## Timing
- Reset values: state IDLE, all gnt/rvalid/mem_we/mem_addr/mem_wdata 0, oob_err 0, beat counter 0, last_owner RD.
- Reset asserted mid-burst aborts immediately. Pending rvalid is dropped; it does not fire after release.
- Grant latency from IDLE: req high at cycle t → gnt high at t+1, first beat at t+1.
- Handover: burst-ending beat at t (gnt still high) → old gnt low and new gnt high at t+1. No idle cycle.
- Read data: beat at t → rvalid and mem_rdata valid at t+1.
- Sustained throughput: 1 beat/cycle. Two continuously requesting masters alternate every MAX_BURST beats (or at last).
- Beat counter width: clog2(MAX_BURST+1); it never wraps.

## Structure
- Package lattice_mem_pkg:
  - NUM_DIR, DATA_WIDTH, DEPTH, ADDRESS_WIDTH, lane width W;
  - owner enum {OWN_NONE, OWN_SOL, OWN_RD};
  - direction-index constants (C0, N, NE, E, SE, S, SW, W, NW → lane order in W).
- One sub-module, arb_rr2: 2-way round-robin pick given two reqs and last_owner; purely combinational.
- FSM, beat counter, muxes, rvalid pipeline and oob flag live in the top.

## Test plan
- Solver only, 4-beat write burst to addresses 0–3 (last on beat 4), then 4-beat read of 0–3 → sol_gnt high cycles 1–4 then low; mem_we high exactly 4 cycles; sol_rvalid on 4 consecutive cycles one after each read beat, data matches written values.
- Both req asserted same cycle from reset → solver granted first. Solver streams without last for MAX_BURST=16 beats → rd_gnt high the very next cycle, no gap.
- Readout burst with rd_last on beat 3 while solver requesting → solver gnt on cycle after beat 3; last_owner=RD.
- Solver drops req mid-burst at beat 2 → no beat that cycle, gnt low next cycle, IDLE if rd_req low.
- Solver write to address 2500 → mem_we stays 0, oob_err rises next cycle and stays high; read of 2600 still yields sol_rvalid.
- rst asserted the cycle after a read beat → rvalid stays 0, all outputs 0 asynchronously; after release, first request is granted in 1 cycle.
